// File: rtl/fetch_stage.sv
// Instruction fetch: PC register feeding a 2-entry {pc, instr} skid FIFO toward decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_stall counters.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  logic [63:0] pc_reg, pc_next;
  logic [1:0]  count_reg, count_next;
  logic        head_reg, head_next;
  logic [63:0] ent_pc_reg    [2];
  logic [31:0] ent_instr_reg [2];
  logic        pop, push, tail;

  assign imem_addr = pc_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_pc    = ent_pc_reg[head_reg];
  assign out_instr = ent_instr_reg[head_reg];

  assign pop  = out_valid & out_ready;
  assign push = !redirect_valid & ((count_reg < 2'd2) | pop);
  // When full and popping, the tail slot is the one being vacated by the head.
  assign tail = head_reg ^ (count_reg == 2'd1);

  always_comb begin
    pc_next    = pc_reg;
    count_next = count_reg;
    head_next  = head_reg;
    if (redirect_valid) begin
      pc_next    = redirect_pc & ~64'h3;
      count_next = 2'd0;
      head_next  = 1'b0;
    end else begin
      if (pop)
        head_next = ~head_reg;
      if (push)
        pc_next = pc_reg + 64'd4;
      count_next = count_reg + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      count_reg <= 2'd0;
      head_reg  <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_pc_reg[gi]    <= 64'h0;
          ent_instr_reg[gi] <= 32'h0;
        end else if (push && (tail == 1'(gi))) begin
          ent_pc_reg[gi]    <= pc_reg;
          ent_instr_reg[gi] <= imem_instr;
        end
      end
    end
  endgenerate

`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = (count_reg == 2'd2) & !pop & !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (push && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (stall && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
